// File: rtl/mc_mem_ctrl.sv
// Multi-cycle memory access controller: turns one-cycle CPU requests into
// readM/writeM bus accesses of LATENCY cycles, owns the data bus tri-state.
module mc_mem_ctrl #(
   parameter int WORD_SIZE  = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int LATENCY    = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [WORD_SIZE-1:0]  req_wdata,
   output logic                  req_ready,
   output logic                  resp_valid,
   output logic [WORD_SIZE-1:0]  resp_rdata,
   output logic                  stall,
   output logic                  readM,
   output logic                  writeM,
   output logic [ADDR_WIDTH-1:0] address,
   inout  wire  [WORD_SIZE-1:0]  data,
   output logic [CNT_WIDTH-1:0]  rd_count,
   output logic [CNT_WIDTH-1:0]  wr_count,
   output logic [CNT_WIDTH-1:0]  stall_count
);

   typedef enum logic {IDLE, ACCESS} state_t;

   localparam logic [3:0]           WAIT_INIT = 4'(LATENCY - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t               state;
   logic [3:0]           wait_cnt;
   logic [WORD_SIZE-1:0] wdata_q;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   // The bus is only ours while a write is on it; memory drives it on reads.
   assign data = writeM ? wdata_q : {WORD_SIZE{1'bz}};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         wait_cnt    <= 4'd0;
         readM       <= 1'b0;
         writeM      <= 1'b0;
         address     <= '0;
         resp_valid  <= 1'b0;
         resp_rdata  <= '0;
         req_ready   <= 1'b1;
         stall       <= 1'b0;
         rd_count    <= '0;
         wr_count    <= '0;
         stall_count <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  state     <= ACCESS;
                  wait_cnt  <= WAIT_INIT;
                  address   <= req_addr;
                  wdata_q   <= req_wdata;
                  readM     <= !req_we;
                  writeM    <= req_we;
                  req_ready <= 1'b0;
                  stall     <= 1'b1;
                  if (req_we) wr_count <= sat_inc(wr_count);
                  else        rd_count <= sat_inc(rd_count);
               end
            end
            ACCESS: begin
               stall_count <= sat_inc(stall_count);
               if (wait_cnt == 4'd0) begin
                  // Closing edge: memory data is valid now, release the bus.
                  state      <= IDLE;
                  readM      <= 1'b0;
                  writeM     <= 1'b0;
                  req_ready  <= 1'b1;
                  stall      <= 1'b0;
                  resp_valid <= 1'b1;
                  if (!writeM) resp_rdata <= data;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_mem_ctrl.sv
// Directed bench for mc_mem_ctrl: LATENCY=2 main instance, a 4-bit counter
// instance for saturation and a LATENCY=1 instance for back-to-back reads.
module tb_mc_mem_ctrl;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory model: fixed background pattern plus cells written by u1.
   bit          wflag [256];
   logic [15:0] wmem  [256];

   function automatic logic [15:0] mem_rd(input logic [7:0] a);
      if (wflag[a]) return wmem[a];
      if (a == 8'h10) return 16'h1234;
      return 16'hA000 | {8'h00, a};
   endfunction

   // ---------------- instance 1: LATENCY=2, CNT_WIDTH=16
   logic        v1, we1, ready1, rv1, st1, rd1, w1;
   logic [15:0] ra1, wd1, rdata1, a1, rc1, wc1, sc1;
   wire  [15:0] d1;
   assign d1 = rd1 ? mem_rd(a1[7:0]) : 16'hzzzz;
   always @(posedge clk) if (w1) begin
      wflag[a1[7:0]] <= 1'b1;
      wmem[a1[7:0]]  <= d1;
   end

   mc_mem_ctrl #(.WORD_SIZE(16), .ADDR_WIDTH(16), .LATENCY(2), .CNT_WIDTH(16)) u1 (
      .clk(clk), .reset_n(reset_n), .req_valid(v1), .req_we(we1), .req_addr(ra1),
      .req_wdata(wd1), .req_ready(ready1), .resp_valid(rv1), .resp_rdata(rdata1),
      .stall(st1), .readM(rd1), .writeM(w1), .address(a1), .data(d1),
      .rd_count(rc1), .wr_count(wc1), .stall_count(sc1));

   // ---------------- instance 2: LATENCY=2, CNT_WIDTH=4
   logic        v2, ready2, rv2, st2, rd2, w2;
   logic [15:0] ra2, rdata2, a2;
   logic [3:0]  rc2, wc2, sc2;
   wire  [15:0] d2;
   assign d2 = rd2 ? mem_rd(a2[7:0]) : 16'hzzzz;

   mc_mem_ctrl #(.WORD_SIZE(16), .ADDR_WIDTH(16), .LATENCY(2), .CNT_WIDTH(4)) u2 (
      .clk(clk), .reset_n(reset_n), .req_valid(v2), .req_we(1'b0), .req_addr(ra2),
      .req_wdata(16'h0000), .req_ready(ready2), .resp_valid(rv2), .resp_rdata(rdata2),
      .stall(st2), .readM(rd2), .writeM(w2), .address(a2), .data(d2),
      .rd_count(rc2), .wr_count(wc2), .stall_count(sc2));

   // ---------------- instance 3: LATENCY=1, CNT_WIDTH=16
   logic        v3, ready3, rv3, st3, rd3, w3;
   logic [15:0] ra3, rdata3, a3, rc3, wc3, sc3;
   wire  [15:0] d3;
   assign d3 = rd3 ? mem_rd(a3[7:0]) : 16'hzzzz;

   mc_mem_ctrl #(.WORD_SIZE(16), .ADDR_WIDTH(16), .LATENCY(1), .CNT_WIDTH(16)) u3 (
      .clk(clk), .reset_n(reset_n), .req_valid(v3), .req_we(1'b0), .req_addr(ra3),
      .req_wdata(16'h0000), .req_ready(ready3), .resp_valid(rv3), .resp_rdata(rdata3),
      .stall(st3), .readM(rd3), .writeM(w3), .address(a3), .data(d3),
      .rd_count(rc3), .wr_count(wc3), .stall_count(sc3));

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0;
      v1 = 1'b0; we1 = 1'b0; ra1 = 16'h0; wd1 = 16'h0;
      v2 = 1'b0; ra2 = 16'h0;
      v3 = 1'b0; ra3 = 16'h0;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(ready1), 32'd1);
      check("rst_stall", 32'(st1), 32'd0);
      check("rst_readM", 32'(rd1), 32'd0);
      check("rst_addr", 32'(a1), 32'h0);
      check("rst_rcount", 32'(rc1), 32'h0);
      reset_n = 1'b1;

      // Read 0x0010 -> 0x1234
      v1 = 1'b1; we1 = 1'b0; ra1 = 16'h0010;
      @(negedge clk);
      check("t1_readM_c1", 32'(rd1), 32'd1);
      check("t1_stall_c1", 32'(st1), 32'd1);
      check("t1_addr", 32'(a1), 32'h0010);
      check("t1_ready_c1", 32'(ready1), 32'd0);
      v1 = 1'b0;
      @(negedge clk);
      check("t1_readM_c2", 32'(rd1), 32'd1);
      check("t1_stall_c2", 32'(st1), 32'd1);
      @(negedge clk);
      check("t1_resp_valid", 32'(rv1), 32'd1);
      check("t1_rdata", 32'(rdata1), 32'h1234);
      check("t1_readM_done", 32'(rd1), 32'd0);
      check("t1_stall_done", 32'(st1), 32'd0);
      check("t1_rcount", 32'(rc1), 32'd1);

      // Write 0x00AA -> 0x0020, read it back from the resp_valid cycle
      v1 = 1'b1; we1 = 1'b1; ra1 = 16'h0020; wd1 = 16'h00AA;
      @(negedge clk);
      check("t2_writeM_c1", 32'(w1), 32'd1);
      check("t2_bus", 32'(d1), 32'h00AA);
      check("t2_addr", 32'(a1), 32'h0020);
      check("t2_readM_off", 32'(rd1), 32'd0);
      v1 = 1'b0;
      @(negedge clk);
      check("t2_writeM_c2", 32'(w1), 32'd1);
      @(negedge clk);
      check("t2_wr_resp", 32'(rv1), 32'd1);
      check("t2_writeM_off", 32'(w1), 32'd0);
      check("t2_wcount", 32'(wc1), 32'd1);
      check("t2_rdata_kept", 32'(rdata1), 32'h1234);
      v1 = 1'b1; we1 = 1'b0; ra1 = 16'h0020;
      @(negedge clk);
      check("t2_rd_readM", 32'(rd1), 32'd1);
      check("t2_rd_resp_off", 32'(rv1), 32'd0);
      v1 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("t2_rd_resp", 32'(rv1), 32'd1);
      check("t2_rd_data", 32'(rdata1), 32'h00AA);
      check("t2_rcount", 32'(rc1), 32'd2);
      check("t2_wcount_end", 32'(wc1), 32'd1);
      check("t2_scount", 32'(sc1), 32'd6);

      // Held request with changing address during ACCESS
      v1 = 1'b1; we1 = 1'b0; ra1 = 16'h0030;
      @(negedge clk);
      check("t3_addr_c1", 32'(a1), 32'h0030);
      ra1 = 16'h0031;
      @(negedge clk);
      check("t3_addr_c2", 32'(a1), 32'h0030);
      ra1 = 16'h0032;
      @(negedge clk);
      check("t3_resp", 32'(rv1), 32'd1);
      check("t3_rdata", 32'(rdata1), 32'hA030);
      check("t3_rcount", 32'(rc1), 32'd3);
      v1 = 1'b0;
      @(negedge clk);
      check("t3_resp_once", 32'(rv1), 32'd0);
      check("t3_idle_ready", 32'(ready1), 32'd1);

      // Reset in the second ACCESS cycle of a write
      v1 = 1'b1; we1 = 1'b1; ra1 = 16'h0040; wd1 = 16'h5555;
      @(negedge clk);
      check("t4_writeM_c1", 32'(w1), 32'd1);
      v1 = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check("t4_writeM", 32'(w1), 32'd0);
      check("t4_resp", 32'(rv1), 32'd0);
      check("t4_ready", 32'(ready1), 32'd1);
      check("t4_stall", 32'(st1), 32'd0);
      check("t4_addr", 32'(a1), 32'h0);
      check("t4_rdata", 32'(rdata1), 32'h0);
      check("t4_counts", {rc1, wc1}, 32'h0);
      check("t4_scount", 32'(sc1), 32'h0);
      reset_n = 1'b1;
      @(negedge clk);
      check("t4_no_resp", 32'(rv1), 32'd0);

      // 20 reads on the 4-bit counter instance
      for (int i = 0; i < 20; i++) begin
         v2 = 1'b1; ra2 = 16'(i);
         @(negedge clk);
         v2 = 1'b0;
         @(negedge clk);
         @(negedge clk);
         if (i == 2) begin
            check("t5_rcount_3", 32'(rc2), 32'd3);
            check("t5_scount_6", 32'(sc2), 32'd6);
         end
      end
      check("t5_rcount_sat", 32'(rc2), 32'hF);
      check("t5_scount_sat", 32'(sc2), 32'hF);
      check("t5_wcount", 32'(wc2), 32'h0);
      check("t5_last_data", 32'(rdata2), 32'hA013);

      // LATENCY=1 back-to-back reads
      v3 = 1'b1; ra3 = 16'h0050;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t6_readM", 32'(rd3), 32'd1);
         check("t6_addr", 32'(a3), 32'(16'h0050 + 16'(k)));
         check("t6_resp_off", 32'(rv3), 32'd0);
         ra3 = 16'h0050 + 16'(k + 1);
         @(negedge clk);
         check("t6_resp", 32'(rv3), 32'd1);
         check("t6_readM_off", 32'(rd3), 32'd0);
         check("t6_rdata", 32'(rdata3), 32'(16'hA050 + 16'(k)));
         if (k == 3) v3 = 1'b0;
      end
      check("t6_rcount", 32'(rc3), 32'd4);
      check("t6_scount", 32'(sc3), 32'd4);
      @(negedge clk);
      check("t6_idle", 32'(st3), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
